// File: rtl/keypad_event.sv
// keypad_event: debounces the keypad scanner's one-hot active-low key vector
// and queues one 4-bit key code per accepted press in a small FWFT FIFO.
//   clk       clock
//   rstn      asynchronous active-low reset
//   key_data  scanner vector, active-low one-hot, all-ones = no key
//   key_ready consumer accepts the head entry
//   clr_ovf   synchronous clear of the overflow flag
//   key_code  head entry code
//   key_valid FIFO holds at least one entry
//   key_held  a debounced key is currently down
//   overflow  sticky: an event was dropped because the FIFO was full
module keypad_event #(
   parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
   parameter int          CNT_W           = 16,
   parameter int          FIFO_DEPTH      = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [11:0] key_data,
   input  logic        key_ready,
   input  logic        clr_ovf,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic        overflow
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   // code for bit i lives in MAP[4*i +: 4]; bit 11 is the MSB nibble
   localparam logic [47:0] MAP = {4'h1, 4'h4, 4'h7, 4'hA, 4'h2, 4'h5,
                                  4'h8, 4'h0, 4'h3, 4'h6, 4'h9, 4'hB};

   typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [11:0]      key_q;
   logic [3:0]       cand;
   logic             ev_push;
   logic [11:0]      zeros;
   logic             none;
   logic             single;
   logic             match;
   logic [3:0]       samp_code;
   logic [3:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      count;
   logic             full;
   logic             pop;
   logic             wr;

   assign zeros  = ~key_q;
   assign none   = zeros == 12'd0;
   // clearing the lowest set bit leaves zero only for a one-hot vector
   assign single = !none && ((zeros & (zeros - 12'd1)) == 12'd0);
   assign match  = single && samp_code == cand;

   always_comb begin
      samp_code = 4'h0;
      for (int i = 0; i < 12; i++)
         if (!key_q[i]) samp_code = MAP[i*4 +: 4];
   end

   // ev_push and key_held are registered, so both appear one cycle after
   // the state change that causes them
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= '0;
         key_q    <= '1;
         cand     <= 4'h0;
         ev_push  <= 1'b0;
         key_held <= 1'b0;
      end else begin
         key_q    <= key_data;
         ev_push  <= 1'b0;
         key_held <= state == PRESSED || state == DB_RELEASE;
         case (state)
            IDLE:
               if (single) begin
                  cand  <= samp_code;
                  cnt   <= '0;
                  state <= DB_PRESS;
               end
            DB_PRESS:
               if (!match) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == LAST) begin
                  ev_push <= 1'b1;
                  state   <= PRESSED;
               end else cnt <= cnt + 1'b1;
            PRESSED:
               if (none) begin
                  cnt   <= '0;
                  state <= DB_RELEASE;
               end
            default:
               if (!none) state <= PRESSED;
               else if (cnt == LAST) state <= IDLE;
               else cnt <= cnt + 1'b1;
         endcase
      end
   end

   assign full      = count == FULL;
   assign key_valid = count != '0;
   assign key_code  = mem[rp];
   assign pop       = key_valid && key_ready;
   assign wr        = ev_push && (!full || pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'h0;
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) begin
            mem[wp] <= cand;
            wp      <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         count <= count + (AW+1)'(wr) - (AW+1)'(pop);
         // a drop in the same cycle as clr_ovf keeps the flag set
         if (ev_push && full && !pop) overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_keypad_event.sv
// tb_keypad_event: directed self-checking bench for keypad_event with a
// short debounce window and a 4-entry FIFO.
module tb_keypad_event;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [11:0] key_data = 12'hFFF;
   logic        key_ready = 1'b1;
   logic        clr_ovf = 1'b0;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic        overflow;
   int          n_assert = 0;
   int          n_fail = 0;
   logic [3:0]  got [$];
   logic [3:0]  sweep [12] = '{4'h1, 4'h4, 4'h7, 4'hA, 4'h2, 4'h5,
                               4'h8, 4'h0, 4'h3, 4'h6, 4'h9, 4'hB};

   keypad_event #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rstn(rstn), .key_data(key_data), .key_ready(key_ready),
      .clr_ovf(clr_ovf), .key_code(key_code), .key_valid(key_valid),
      .key_held(key_held), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // log every handshake; inputs change 2 units after posedge, so the
   // negedge sees exactly what the next posedge will act on
   always @(negedge clk)
      if (rstn && key_valid && key_ready) got.push_back(key_code);

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press(input int b, input int lo, input int hi);
      key_data = ~(12'd1 << b);
      tick(lo);
      key_data = 12'hFFF;
      tick(hi);
   endtask

   initial begin
      tick(3);
      chk("rst_code", key_code, 4'h0);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_held", key_held, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      rstn = 1'b1;
      tick(2);

      // single press of bit 6, 20 cycles low
      got.delete();
      key_data = ~12'h040;
      for (int c = 0; c < 30; c++) begin
         tick(1);
         chk($sformatf("t1_valid_%0d", c), key_valid, c == 6);
         chk($sformatf("t1_held_%0d", c), key_held, c >= 6 && c < 26);
         if (c == 6) chk("t1_code", key_code, 4'h5);
         if (c == 19) key_data = 12'hFFF;
      end
      chk("t1_events", got.size(), 1);

      // bounce: never more than 3 stable samples
      got.delete();
      for (int r = 0; r < 5; r++) begin
         key_data = ~12'h010;
         for (int c = 0; c < 3; c++) begin
            tick(1);
            chk("t2_held", key_held, 1'b0);
         end
         key_data = 12'hFFF;
         tick(1);
      end
      tick(8);
      chk("t2_valid", key_valid, 1'b0);
      chk("t2_held_end", key_held, 1'b0);
      chk("t2_events", got.size(), 0);

      // code map sweep
      got.delete();
      for (int b = 11; b >= 0; b--) press(b, 8, 8);
      chk("t3_events", got.size(), 12);
      for (int i = 0; i < 12; i++)
         if (i < got.size()) chk($sformatf("t3_code_%0d", i), got[i], sweep[i]);

      // overflow with consumer stalled
      key_ready = 1'b0;
      for (int p = 0; p < 4; p++) press(11, 8, 8);
      chk("t4_ovf_at_full", overflow, 1'b0);
      press(11, 8, 8);
      chk("t4_valid", key_valid, 1'b1);
      chk("t4_ovf", overflow, 1'b1);
      chk("t4_code", key_code, 4'h1);
      got.delete();
      key_ready = 1'b1;
      tick(4);
      key_ready = 1'b0;
      chk("t4_valid_drained", key_valid, 1'b0);
      chk("t4_pops", got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < got.size()) chk($sformatf("t4_pop_%0d", i), got[i], 4'h1);
      tick(3);
      chk("t4_ovf_sticky", overflow, 1'b1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("t4_ovf_clr", overflow, 1'b0);

      // held key joined by a second key, then a start from a multi-key state
      got.delete();
      key_ready = 1'b1;
      key_data = ~12'h001;
      tick(8);
      key_data = ~12'h009;
      tick(8);
      chk("t5_held_multi", key_held, 1'b1);
      key_data = 12'hFFF;
      tick(10);
      chk("t5_held_rel", key_held, 1'b0);
      chk("t5_events", got.size(), 1);
      if (got.size() > 0) chk("t5_code", got[0], 4'hB);
      got.delete();
      key_data = ~12'h009;
      tick(10);
      chk("t5_multi_held", key_held, 1'b0);
      key_data = 12'hFFF;
      tick(10);
      chk("t5_multi_events", got.size(), 0);

      // reset with two queued events and a press mid-debounce
      key_ready = 1'b0;
      press(7, 8, 8);
      press(7, 8, 8);
      chk("t6_pre_valid", key_valid, 1'b1);
      chk("t6_pre_code", key_code, 4'h2);
      key_data = ~12'h004;
      tick(3);
      rstn = 1'b0;
      #1;
      chk("t6_code", key_code, 4'h0);
      chk("t6_valid", key_valid, 1'b0);
      chk("t6_held", key_held, 1'b0);
      chk("t6_ovf", overflow, 1'b0);
      key_data = 12'hFFF;
      tick(2);
      rstn = 1'b1;
      key_ready = 1'b1;
      got.delete();
      tick(15);
      chk("t6_post_valid", key_valid, 1'b0);
      chk("t6_post_events", got.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/keypad_event.md
# keypad_event

Press-event extractor that sits directly downstream of the 3-column keypad scanner. It consumes the scanner's registered 12-bit active-low one-hot key vector and debounces it. Each debounced press becomes one 4-bit key code. Codes are buffered in a small FIFO and handed to the consumer (display/command logic) over a valid/ready handshake.

## Interface
- DEBOUNCE_CYCLES, default 16'd50000: consecutive stable cycles required to accept a press or release; must be >= 2.
- CNT_W, default 16: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- FIFO_DEPTH, default 4: event buffer entries; power of two.
- clk  input  1: clock.
- rstn  input  1: reset, asynchronous, active-low.
- key_data  input  12: scanner output, active-low one-hot, synchronous to clk; all-ones means no key.
- key_ready  input  1: consumer accepts head entry.
- clr_ovf  input  1: synchronous clear of overflow.
- key_code  output  4: FIFO head code.
- key_valid  output  1: FIFO non-empty.
- key_held  output  1: a debounced key is currently down.
- overflow  output  1: sticky flag, an event was dropped.

## Operation
- Bit-to-code map (bit index -> code):
  - 11->1, 10->4, 9->7, 8->*=4'hA.
  - 7->2, 6->5, 5->8, 4->0.
  - 3->3, 2->6, 1->9, 0->#=4'hB.
- Sample classification on key_q, a one-cycle register of key_data:
  - NONE: all ones.
  - SINGLE: exactly one zero bit.
  - MULTI: anything else.
- FSM states: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
- IDLE:
  - SINGLE -> latch cand code, clear cnt, go DB_PRESS.
  - NONE/MULTI -> stay.
- DB_PRESS:
  - Sample not SINGLE with code == cand -> IDLE, cnt cleared.
  - Else cnt++; when cnt == DEBOUNCE_CYCLES-1 -> push cand, go PRESSED.
- PRESSED:
  - NONE -> clear cnt, go DB_RELEASE.
  - Anything else, including a different key or MULTI -> stay. No new event until release.
- DB_RELEASE:
  - Non-NONE -> back to PRESSED.
  - cnt == DEBOUNCE_CYCLES-1 with NONE -> IDLE.
- key_held = state is PRESSED or DB_RELEASE.
- FIFO is first-word-fall-through:
  - key_code = head entry; key_valid = count != 0.
  - Pop when key_valid && key_ready.
- Push while full without a simultaneous pop: event dropped, FIFO contents unchanged, overflow set.
- Push and pop in the same cycle when full: both happen, no overflow.
- No bypass: a push into an empty FIFO is visible the next cycle.
- overflow:
  - Cleared by clr_ovf or reset.
  - If clr_ovf and an overflowing push coincide, set wins.
- Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - state IDLE; cnt 0; key_q all ones; FIFO empty.
  - key_code 4'h0; key_valid 0; key_held 0; overflow 0.
- Press latency: key_data first shows a stable SINGLE value before edge 0. key_valid and key_held rise after edge DEBOUNCE_CYCLES+2.
- Release latency: key_data first all-ones before edge 0. key_held falls after edge DEBOUNCE_CYCLES+2.
- A glitch of any length shorter than DEBOUNCE_CYCLES+1 stable samples produces no event.
- key_valid drops the cycle after the last entry is popped.
- rstn assertion mid-debounce or with a non-empty FIFO: all state cleared immediately. Pending events are lost. No event is produced by the first post-reset samples unless they satisfy a full debounce.

## Test plan
- DEBOUNCE_CYCLES=4, key_ready=1. Drive bit 6 low for 20 cycles then all ones.
  - key_valid high for exactly 1 cycle, 6 cycles after the edge, with key_code=5.
  - key_held high from that edge until 6 cycles after release.
- Bounce rejection: bit 4 low for 3 cycles, high 1, low 3, repeated 5 times.
  - No key_valid; key_held stays 0.
- Map sweep: press and release each of the 12 bits in turn, key_ready=1.
  - Codes 1,4,7,A,2,5,8,0,3,6,9,B in order.
- Overflow, key_ready=0: five debounced presses of bit 11.
  - count 4, key_valid=1, overflow=1, key_code=1.
  - Then key_ready=1 for 4 cycles -> four pops; key_valid=0; overflow stays 1 until clr_ovf pulsed.
- Multi/held key: press bit 0, after debounce add bit 3 low, then release all.
  - Exactly one event, code B.
  - Separately, start from MULTI (bits 0 and 3 low) -> no event.
- Reset mid-operation: assert rstn low during DB_PRESS and with 2 queued events.
  - All outputs at reset values next sample; no events after release of reset while key_data is all ones.
